// File: rtl/instr_mem_pipe_if.sv
// Fetch request/response and program-load bus for instr_mem_pipe.
// The master side drives requests and loads, the slave side is the memory.
interface instr_mem_pipe_if #(
  parameter int unsigned ADDR_WIDTH_POW  = 6,
  parameter int unsigned MEM_DEPTH_POW   = 10,
  parameter int unsigned FETCH_WORDS_POW = 0
);
  localparam int unsigned AddrWidth  = 1 << ADDR_WIDTH_POW;
  localparam int unsigned FetchWords = 1 << FETCH_WORDS_POW;

  logic                     fetch_valid_in;
  logic                     fetch_ready_out;
  logic [AddrWidth-1:0]     fetch_addr_in;
  logic                     resp_valid_out;
  logic                     resp_ready_in;
  logic [32*FetchWords-1:0] resp_instr_out;
  logic [AddrWidth-1:0]     resp_addr_out;
  logic [1:0]               resp_fault_out;
  logic                     load_en_in;
  logic [MEM_DEPTH_POW-1:0] load_addr_in;
  logic [31:0]              load_data_in;
  logic [3:0]               load_be_in;
  logic [31:0]              fetch_count_out;

  modport master (
    output fetch_valid_in, fetch_addr_in, resp_ready_in,
    output load_en_in, load_addr_in, load_data_in, load_be_in,
    input  fetch_ready_out, resp_valid_out, resp_instr_out, resp_addr_out,
    input  resp_fault_out, fetch_count_out
  );

  modport slave (
    input  fetch_valid_in, fetch_addr_in, resp_ready_in,
    input  load_en_in, load_addr_in, load_data_in, load_be_in,
    output fetch_ready_out, resp_valid_out, resp_instr_out, resp_addr_out,
    output resp_fault_out, fetch_count_out
  );
endinterface

// File: rtl/instr_mem_pipe.sv
// Synchronous-read instruction memory with valid/ready fetch handshake, 1-cycle
// registered response, multi-word fetch blocks, byte-enabled load port and fault reporting.
module instr_mem_pipe #(
  parameter int unsigned ADDR_WIDTH_POW  = 6,
  parameter int unsigned MEM_DEPTH_POW   = 10,
  parameter int unsigned FETCH_WORDS_POW = 0
) (
  input logic              clk_in,
  input logic              rst_n_in,
  instr_mem_pipe_if.slave  bus
);
  localparam int unsigned AddrWidth  = 1 << ADDR_WIDTH_POW;
  localparam int unsigned MemDepth   = 1 << MEM_DEPTH_POW;
  localparam int unsigned FetchWords = 1 << FETCH_WORDS_POW;
  localparam logic [AddrWidth:0] LastOffset = (AddrWidth + 1)'(FetchWords - 1);
  localparam logic [AddrWidth:0] DepthWide  = (AddrWidth + 1)'(MemDepth);

  logic [31:0] ram [MemDepth];

  logic                     resp_valid_q, resp_valid_d;
  logic [32*FetchWords-1:0] resp_instr_q, resp_instr_d;
  logic [AddrWidth-1:0]     resp_addr_q, resp_addr_d;
  logic [1:0]               resp_fault_q, resp_fault_d;
  logic [31:0]              count_q, count_d;

  logic                     ready;
  logic                     accept;
  logic [AddrWidth:0]       word_full;
  logic [AddrWidth:0]       last_word;
  logic [MEM_DEPTH_POW-1:0] word_idx;
  logic [MEM_DEPTH_POW-1:0] k_off;
  logic [1:0]               fault;
  logic [32*FetchWords-1:0] rdata;

  // Load owns the single array port, so it blocks fetch acceptance.
  assign ready  = !bus.load_en_in && (!resp_valid_q || bus.resp_ready_in);
  assign accept = bus.fetch_valid_in && ready;

  // One extra bit keeps the end-of-block check free of wraparound.
  always_comb begin
    word_full = {1'b0, bus.fetch_addr_in} >> 2;
    word_idx  = word_full[MEM_DEPTH_POW-1:0];
    last_word = word_full + LastOffset;
    if (bus.fetch_addr_in[1:0] != 2'b00) begin
      fault = 2'b01;
    end else if (last_word >= DepthWide) begin
      fault = 2'b10;
    end else begin
      fault = 2'b00;
    end
  end

  always_comb begin
    rdata = '0;
    k_off = '0;
    for (int k = 0; k < FetchWords; k++) begin
      k_off = k[MEM_DEPTH_POW-1:0];
      rdata[32*k +: 32] = ram[word_idx + k_off];
    end
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_instr_d = resp_instr_q;
    resp_addr_d  = resp_addr_q;
    resp_fault_d = resp_fault_q;
    count_d      = count_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_instr_d = (fault == 2'b00) ? rdata : '0;
      resp_addr_d  = bus.fetch_addr_in;
      resp_fault_d = fault;
      count_d      = count_q + 32'd1;
    end else if (bus.resp_ready_in) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      resp_valid_q <= 1'b0;
      resp_instr_q <= '0;
      resp_addr_q  <= '0;
      resp_fault_q <= 2'b00;
      count_q      <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_instr_q <= resp_instr_d;
      resp_addr_q  <= resp_addr_d;
      resp_fault_q <= resp_fault_d;
      count_q      <= count_d;
    end
  end

  // Contents survive reset; only the write is suppressed in the reset cycle.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && bus.load_en_in) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.load_be_in[i]) begin
          ram[bus.load_addr_in][8*i +: 8] <= bus.load_data_in[8*i +: 8];
        end
      end
    end
  end

  assign bus.fetch_ready_out = ready;
  assign bus.resp_valid_out  = resp_valid_q;
  assign bus.resp_instr_out  = resp_instr_q;
  assign bus.resp_addr_out   = resp_addr_q;
  assign bus.resp_fault_out  = resp_fault_q;
  assign bus.fetch_count_out = count_q;
endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed bench for instr_mem_pipe: single-word and two-word fetch instances driven in
// lockstep, table of load/fetch vectors plus hand sequences for hold, load and reset cases.
module tb_instr_mem_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  instr_mem_pipe_if #(.FETCH_WORDS_POW(0)) bus0 ();
  instr_mem_pipe_if #(.FETCH_WORDS_POW(1)) bus1 ();

  instr_mem_pipe #(.FETCH_WORDS_POW(0)) u_dut0 (.clk_in(clk), .rst_n_in(rst_n), .bus(bus0));
  instr_mem_pipe #(.FETCH_WORDS_POW(1)) u_dut1 (.clk_in(clk), .rst_n_in(rst_n), .bus(bus1));

  typedef struct {
    logic        ld;
    logic [9:0]  la;
    logic [31:0] ldat;
    logic [3:0]  be;
    logic        fv;
    logic [63:0] fa;
    logic        rdy;
    logic        ev;
    logic [31:0] ei;
    logic [1:0]  ef;
    logic [63:0] ea;
    logic [31:0] ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic ld, logic [9:0] la, logic [31:0] ldat, logic [3:0] be,
                              logic fv, logic [63:0] fa, logic rdy, logic ev,
                              logic [31:0] ei, logic [1:0] ef, logic [63:0] ea,
                              logic [31:0] ec);
    vec_t v;
    v.ld = ld; v.la = la; v.ldat = ldat; v.be = be; v.fv = fv; v.fa = fa;
    v.rdy = rdy; v.ev = ev; v.ei = ei; v.ef = ef; v.ea = ea; v.ec = ec;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic ld, logic [9:0] la, logic [31:0] ldat, logic [3:0] be,
                       logic fv, logic [63:0] fa, logic rr);
    bus0.load_en_in = ld;  bus0.load_addr_in = la;  bus0.load_data_in = ldat;
    bus0.load_be_in = be;  bus0.fetch_valid_in = fv; bus0.fetch_addr_in = fa;
    bus0.resp_ready_in = rr;
    bus1.load_en_in = ld;  bus1.load_addr_in = la;  bus1.load_data_in = ldat;
    bus1.load_be_in = be;  bus1.fetch_valid_in = fv; bus1.fetch_addr_in = fa;
    bus1.resp_ready_in = rr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle on both DUTs and check the single-word DUT's registered response.
  task automatic cyc0(string nm, logic ld, logic [9:0] la, logic [31:0] ldat, logic [3:0] be,
                      logic fv, logic [63:0] fa, logic rr, logic rdy, logic ev,
                      logic [31:0] ei, logic [1:0] ef, logic [63:0] ea, logic [31:0] ec);
    drive(ld, la, ldat, be, fv, fa, rr);
    #1;
    chk({nm, ".ready"}, 64'(bus0.fetch_ready_out), 64'(rdy));
    step();
    chk({nm, ".valid"}, 64'(bus0.resp_valid_out), 64'(ev));
    chk({nm, ".count"}, 64'(bus0.fetch_count_out), 64'(ec));
    if (ev) begin
      chk({nm, ".instr"}, 64'(bus0.resp_instr_out), 64'(ei));
      chk({nm, ".fault"}, 64'(bus0.resp_fault_out), 64'(ef));
      chk({nm, ".addr"}, bus0.resp_addr_out, ea);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a fetch and a load presented: both must be ignored.
    rst_n = 1'b0;
    drive(1'b1, 10'd7, 32'hDEADBEEF, 4'hF, 1'b1, 64'h14, 1'b1);
    step();
    step();
    chk("rst.valid", 64'(bus0.resp_valid_out), 64'd0);
    chk("rst.count", 64'(bus0.fetch_count_out), 64'd0);
    chk("rst.instr", 64'(bus0.resp_instr_out), 64'd0);
    chk("rst.addr", bus0.resp_addr_out, 64'd0);
    chk("rst.fault", 64'(bus0.resp_fault_out), 64'd0);
    rst_n = 1'b1;
    drive(1'b0, 10'd0, 32'd0, 4'h0, 1'b0, 64'd0, 1'b1);
    #1;
    chk("rst.ready", 64'(bus0.fetch_ready_out), 64'd1);
    step();

    //               ld    la       ldat           be    fv    fa
    //               rdy   ev    ei             ef     ea         ec
    tbl.push_back(mk(1'b1, 10'd1022, 32'h11111111, 4'hF, 1'b0, 64'h0,
                     1'b0, 1'b0, 32'h0,         2'b00, 64'h0,     32'd0));
    tbl.push_back(mk(1'b1, 10'd1023, 32'h22222222, 4'hF, 1'b0, 64'h0,
                     1'b0, 1'b0, 32'h0,         2'b00, 64'h0,     32'd0));
    tbl.push_back(mk(1'b1, 10'd5,    32'h00500093, 4'hF, 1'b0, 64'h0,
                     1'b0, 1'b0, 32'h0,         2'b00, 64'h0,     32'd0));
    tbl.push_back(mk(1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 64'h14,
                     1'b1, 1'b1, 32'h00500093,  2'b00, 64'h14,    32'd1));
    tbl.push_back(mk(1'b1, 10'd5,    32'hAABBCCDD, 4'h4, 1'b1, 64'h14,
                     1'b0, 1'b0, 32'h0,         2'b00, 64'h0,     32'd1));
    tbl.push_back(mk(1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 64'h14,
                     1'b1, 1'b1, 32'h00BB0093,  2'b00, 64'h14,    32'd2));
    tbl.push_back(mk(1'b1, 10'd5,    32'hAABBCCDD, 4'h1, 1'b0, 64'h0,
                     1'b0, 1'b0, 32'h0,         2'b00, 64'h0,     32'd2));
    tbl.push_back(mk(1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 64'h14,
                     1'b1, 1'b1, 32'h00BB00DD,  2'b00, 64'h14,    32'd3));
    tbl.push_back(mk(1'b1, 10'd5,    32'hFFFFFFFF, 4'h0, 1'b0, 64'h0,
                     1'b0, 1'b0, 32'h0,         2'b00, 64'h0,     32'd3));
    tbl.push_back(mk(1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 64'h14,
                     1'b1, 1'b1, 32'h00BB00DD,  2'b00, 64'h14,    32'd4));
    tbl.push_back(mk(1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 64'h16,
                     1'b1, 1'b1, 32'h0,         2'b01, 64'h16,    32'd5));
    tbl.push_back(mk(1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 64'h1000,
                     1'b1, 1'b1, 32'h0,         2'b10, 64'h1000,  32'd6));
    tbl.push_back(mk(1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 64'h1001,
                     1'b1, 1'b1, 32'h0,         2'b01, 64'h1001,  32'd7));
    tbl.push_back(mk(1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 64'hFFFFFFFF_FFFFFFFC,
                     1'b1, 1'b1, 32'h0,         2'b10, 64'hFFFFFFFF_FFFFFFFC, 32'd8));
    tbl.push_back(mk(1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 64'hFFC,
                     1'b1, 1'b1, 32'h22222222,  2'b00, 64'hFFC,   32'd9));
    tbl.push_back(mk(1'b0, 10'd0,    32'h0,        4'h0, 1'b1, 64'hFF8,
                     1'b1, 1'b1, 32'h11111111,  2'b00, 64'hFF8,   32'd10));
    tbl.push_back(mk(1'b0, 10'd0,    32'h0,        4'h0, 1'b0, 64'h0,
                     1'b1, 1'b0, 32'h0,         2'b00, 64'h0,     32'd10));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc0($sformatf("vec%0d", i), tbl[i].ld, tbl[i].la, tbl[i].ldat, tbl[i].be,
           tbl[i].fv, tbl[i].fa, 1'b1, tbl[i].rdy, tbl[i].ev, tbl[i].ei, tbl[i].ef,
           tbl[i].ea, tbl[i].ec);
    end

    // Backpressure: response held for 3 cycles, including a load to the same word.
    cyc0("bp.first", 1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 64'h14, 1'b0,
         1'b1, 1'b1, 32'h00BB00DD, 2'b00, 64'h14, 32'd11);
    for (int i = 0; i < 3; i++) begin
      cyc0($sformatf("bp.hold%0d", i), (i == 1), 10'd5, 32'h00000013, 4'hF, 1'b1, 64'hFF8,
           1'b0, 1'b0, 1'b1, 32'h00BB00DD, 2'b00, 64'h14, 32'd11);
    end
    cyc0("bp.rel0", 1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 64'hFF8, 1'b1,
         1'b1, 1'b1, 32'h11111111, 2'b00, 64'hFF8, 32'd12);
    cyc0("bp.rel1", 1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 64'hFFC, 1'b1,
         1'b1, 1'b1, 32'h22222222, 2'b00, 64'hFFC, 32'd13);
    cyc0("bp.rel2", 1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 64'h14, 1'b1,
         1'b1, 1'b1, 32'h00000013, 2'b00, 64'h14, 32'd14);

    // Load in the middle of a fetch stream stalls acceptance for that cycle only.
    cyc0("ls.load", 1'b1, 10'd1022, 32'h33333333, 4'hF, 1'b1, 64'hFF8, 1'b1,
         1'b0, 1'b0, 32'h0, 2'b00, 64'h0, 32'd14);
    cyc0("ls.raw", 1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 64'hFF8, 1'b1,
         1'b1, 1'b1, 32'h33333333, 2'b00, 64'hFF8, 32'd15);

    // Reset while a response is pending; the concurrent load must not land.
    rst_n = 1'b0;
    drive(1'b1, 10'd5, 32'h12345678, 4'hF, 1'b1, 64'hFFC, 1'b0);
    step();
    chk("rr.valid", 64'(bus0.resp_valid_out), 64'd0);
    chk("rr.count", 64'(bus0.fetch_count_out), 64'd0);
    rst_n = 1'b1;
    cyc0("rr.after", 1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 64'h14, 1'b1,
         1'b1, 1'b1, 32'h00000013, 2'b00, 64'h14, 32'd1);

    // Two-word fetch blocks on the second instance.
    drive(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 64'hFF8, 1'b1);
    step();
    chk("fw2.ff8.valid", 64'(bus1.resp_valid_out), 64'd1);
    chk("fw2.ff8.instr", bus1.resp_instr_out, 64'h22222222_33333333);
    chk("fw2.ff8.fault", 64'(bus1.resp_fault_out), 64'd0);
    drive(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 64'hFFC, 1'b1);
    step();
    chk("fw2.ffc.instr", bus1.resp_instr_out, 64'd0);
    chk("fw2.ffc.fault", 64'(bus1.resp_fault_out), 64'd2);
    drive(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 64'hFFA, 1'b1);
    step();
    chk("fw2.ffa.fault", 64'(bus1.resp_fault_out), 64'd1);
    chk("fw2.ffa.addr", bus1.resp_addr_out, 64'hFFA);
    chk("fw2.count", 64'(bus1.fetch_count_out), 64'd4);
    drive(1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 64'h0, 1'b1);
    step();
    chk("fw2.drain", 64'(bus1.resp_valid_out), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
